// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of D grants made while a fetch is pending; ge_max forces the next grant to I.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic ge_max
);

  localparam logic [STARVE_CNT_W-1:0] CNT_ZERO = {STARVE_CNT_W{1'b0}};
  localparam logic [STARVE_CNT_W-1:0] CNT_ONE  = {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STARVE_CNT_W-1:0] CNT_SAT  = {STARVE_CNT_W{1'b1}};
  localparam logic [STARVE_CNT_W-1:0] CNT_LIM  = STARVE_CNT_W'(MAX);

  logic [STARVE_CNT_W-1:0] cnt_r;

  // Counter register: clear wins over increment, increment stops at saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (inc && (cnt_r != CNT_SAT)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign ge_max = (cnt_r >= CNT_LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported L1 memory between the core's fetch and data ports:
// D-priority with an I-starvation guard, req/ack handshake to memory, stall signals to the core.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iinstn,
  output logic              iwait,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic [DATA_W-1:0] drdata,
  output logic              dwait,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_r;
  logic [DATA_W-1:0] irdata_r;
  logic [DATA_W-1:0] drdata_r;
  logic              d_pend_s;
  logic              grant_d_s;
  logic              grant_i_s;
  logic              ack_i_s;
  logic              ack_d_s;
  logic              ge_max_s;
  logic              addr_lsb_unused_s;

  assign d_pend_s  = dreq | dwe;
  assign grant_d_s = (state_r == ARB_IDLE) & d_pend_s & ~ge_max_s;
  assign grant_i_s = (state_r == ARB_IDLE) & ~grant_d_s & ireq;
  assign ack_i_s   = (state_r == ARB_GNT_I) & mem_ack;
  assign ack_d_s   = (state_r == ARB_GNT_D) & mem_ack;

  // Byte offset within the word plays no part in a word-wide memory.
  assign addr_lsb_unused_s = ^{iaddr[1:0], daddr[1:0]};

  mem_arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (grant_d_s & ireq),
    .clr    (grant_i_s | ~ireq),
    .ge_max (ge_max_s)
  );

  // Arbiter FSM: captures the winner's request on grant, holds mem_req until ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {(ADDR_W-2){1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      irdata_r  <= {DATA_W{1'b0}};
      drdata_r  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (grant_d_s) begin
            state_r   <= ARB_GNT_D;
            mem_req   <= 1'b1;
            mem_we    <= dwe;
            mem_addr  <= daddr[ADDR_W-1:2];
            mem_wdata <= dwdata;
          end else if (grant_i_s) begin
            state_r  <= ARB_GNT_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= iaddr[ADDR_W-1:2];
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_GNT_I: begin
          if (mem_ack) begin
            state_r  <= ARB_IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            irdata_r <= mem_rdata;
          end else begin
            state_r <= ARB_GNT_I;
          end
        end
        ARB_GNT_D: begin
          if (mem_ack) begin
            state_r  <= ARB_IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            drdata_r <= mem_rdata;
          end else begin
            state_r <= ARB_GNT_D;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Ack-cycle data bypasses the result register so the core un-stalls with valid data.
  assign iinstn = ack_i_s ? mem_rdata : irdata_r;
  assign drdata = ack_d_s ? mem_rdata : drdata_r;
  assign iwait  = ireq & ~ack_i_s;
  assign dwait  = d_pend_s & ~ack_d_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a bench-owned memory responder
// and a transaction-level reference memory.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata;
  logic [31:0] iinstn, drdata, mem_wdata, mem_rdata;
  logic        iwait, dwait, mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .iinstn(iinstn), .iwait(iwait),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata), .dwait(dwait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = 32'(i);
    if (i == 64) return 32'h0050_0093;
    return (v * 32'h9E37_79B9) ^ 32'hA5A5_0000;
  endfunction

  // memory responder: acks after cur_lat waiting cycles of mem_req
  logic [31:0] mem [256];
  logic        resp_ack = 1'b0;
  logic [31:0] resp_rdata = 32'h0;
  logic        force_ack = 1'b0;
  logic [31:0] force_rdata = 32'h0;
  int          lat_cfg = 0;
  bit          lat_rand = 1'b0;
  int          cur_lat = 0;
  int          wcnt = 0;
  int          n_acks = 0;
  int          n_wr_acks = 0;
  logic [29:0] ack_log[$];

  assign mem_ack   = resp_ack | force_ack;
  assign mem_rdata = force_ack ? force_rdata : resp_rdata;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (wcnt >= cur_lat) begin
          resp_ack   = 1'b1;
          resp_rdata = mem[mem_addr[7:0]];
          if (mem_we) begin
            mem[mem_addr[7:0]] = mem_wdata;
            n_wr_acks++;
          end
          n_acks++;
          ack_log.push_back(mem_addr);
          wcnt = 0;
        end else begin
          resp_ack = 1'b0;
          wcnt++;
        end
      end else begin
        resp_ack = 1'b0;
        wcnt     = 0;
        cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
      end
    end
  end

  logic [31:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // counts stalled cycles until the chosen side's wait drops; -1 on timeout
  task automatic wait_done(input bit side_d, output int stall);
    bit done;
    done  = 1'b0;
    stall = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if ((side_d ? dwait : iwait) == 1'b0) done = 1'b1;
      else stall++;
    end
    if (!done) stall = -1;
  endtask

  initial begin
    int st, base, scnt, we_cyc, wr0, acks0, n_done, mism;
    int i_age, d_age, d_streak;
    bit i_pend, d_pend;
    logic [29:0] exp_a;

    ireq = 1'b0; iaddr = 32'h0; dreq = 1'b0; dwe = 1'b0; daddr = 32'h0; dwdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    lat_cfg = 3;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", {2'b0, mem_addr}, 32'h0);
    chk("rst_iinstn", iinstn, 32'h0);
    chk("rst_drdata", drdata, 32'h0);
    cyc(); reset = 1'b0;

    // 1: lone fetch with 3 waiting cycles
    cyc(); ireq = 1'b1; iaddr = 32'h100;
    wait_done(1'b0, st);
    chk("t1_istall", st, 32'd4);
    chk("t1_mem_addr", {2'b0, mem_addr}, 32'h40);
    chk("t1_iinstn_ack", iinstn, 32'h0050_0093);
    cyc(); ireq = 1'b0; lat_cfg = 0;
    @(negedge clk);
    chk("t1_iinstn_hold", iinstn, 32'h0050_0093);

    // 2: simultaneous I and D, D wins, bubble, then I
    cyc(); base = ack_log.size();
    ireq = 1'b1; iaddr = 32'h100; dreq = 1'b1; daddr = 32'h20;
    wait_done(1'b1, st);
    chk("t2_dstall", st, 32'd1);
    chk("t2_first_addr", {2'b0, ack_log[base]}, 32'h8);
    cyc(); dreq = 1'b0;
    @(negedge clk);
    chk("t2_bubble_req", {31'b0, mem_req}, 32'h0);
    chk("t2_bubble_iwait", {31'b0, iwait}, 32'h1);
    wait_done(1'b0, st);
    chk("t2_istall", st, 32'd0);
    chk("t2_second_addr", {2'b0, ack_log[base+1]}, 32'h40);

    // 3: continuous D and I pressure, ten grants
    cyc(); ireq = 1'b0;
    cyc(); base = ack_log.size();
    ireq = 1'b1; iaddr = 32'h100; dreq = 1'b1; daddr = 32'h20;
    for (int c = 0; c < 300 && ack_log.size() < base + 10; c++) @(negedge clk);
    cyc(); ireq = 1'b0; dreq = 1'b0; lat_cfg = 1;
    scnt = 0;
    for (int k = 0; k < 10; k++) begin
      exp_a = (scnt < STARVE_MAX) ? 30'h8 : 30'h40;
      scnt  = (scnt < STARVE_MAX) ? scnt + 1 : 0;
      chk($sformatf("t3_grant%0d", k), {2'b0, ack_log[base+k]}, {2'b0, exp_a});
    end

    // 4: store held through ack is issued once, then read back
    cyc(); wr0 = n_wr_acks;
    dwe = 1'b1; daddr = 32'h44; dwdata = 32'hDEAD_BEEF;
    we_cyc = 0; st = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (mem_req && mem_we) we_cyc++;
      if (!dwait) begin st = c; break; end
    end
    chk("t4_dstall", st, 32'd2);
    cyc(); dwe = 1'b0;
    ref_mem[8'h11] = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_req && mem_we) we_cyc++;
    end
    chk("t4_we_cycles", we_cyc, 32'd2);
    chk("t4_write_count", n_wr_acks - wr0, 32'd1);
    chk("t4_mem_word", mem[8'h11], 32'hDEAD_BEEF);
    cyc(); dreq = 1'b1; daddr = 32'h44;
    wait_done(1'b1, st);
    chk("t4_rd_stall", st, 32'd2);
    chk("t4_rd_data", drdata, 32'hDEAD_BEEF);
    cyc(); dreq = 1'b0; lat_cfg = 5;
    @(negedge clk);
    chk("t4_rd_hold", drdata, 32'hDEAD_BEEF);

    // 5: reset in the middle of a D grant
    cyc(); dreq = 1'b1; daddr = 32'h20;
    @(negedge clk); @(negedge clk);
    chk("t5_in_grant", {31'b0, mem_req}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_req", {31'b0, mem_req}, 32'h0);
    chk("t5_async_we", {31'b0, mem_we}, 32'h0);
    lat_cfg = 0;
    cyc(); dreq = 1'b0;
    cyc(); reset = 1'b0;
    @(negedge clk);
    chk("t5_drdata", drdata, 32'h0);
    chk("t5_iinstn", iinstn, 32'h0);
    chk("t5_mem_req", {31'b0, mem_req}, 32'h0);
    cyc(); ireq = 1'b1; iaddr = 32'h100;
    wait_done(1'b0, st);
    chk("t5_idle_stall", st, 32'd1);
    chk("t5_fetch", iinstn, 32'h0050_0093);

    // 6: spurious ack in IDLE
    cyc(); ireq = 1'b0; dreq = 1'b1; daddr = 32'h44;
    wait_done(1'b1, st);
    chk("t6_prep_rd", drdata, 32'hDEAD_BEEF);
    cyc(); dreq = 1'b0;
    cyc(); force_rdata = 32'h1234_5678; force_ack = 1'b1;
    @(negedge clk);
    chk("t6_ack_iinstn", iinstn, 32'h0050_0093);
    chk("t6_ack_drdata", drdata, 32'hDEAD_BEEF);
    chk("t6_ack_waits", {30'b0, iwait, dwait}, 32'h0);
    cyc(); force_ack = 1'b0;
    @(negedge clk);
    chk("t6_post_req", {31'b0, mem_req}, 32'h0);
    chk("t6_post_iinstn", iinstn, 32'h0050_0093);
    chk("t6_post_drdata", drdata, 32'hDEAD_BEEF);
    cyc(); ireq = 1'b1; iaddr = 32'h100;
    wait_done(1'b0, st);
    chk("t6_idle_stall", st, 32'd1);
    cyc(); ireq = 1'b0; lat_rand = 1'b1;

    // random traffic against the reference memory
    cyc();
    acks0 = n_acks; n_done = 0; i_pend = 1'b0; d_pend = 1'b0;
    i_age = 0; d_age = 0; d_streak = 0;
    for (int c = 0; c < 700; c++) begin
      cyc();
      if (!i_pend && c < 600 && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1; ireq = 1'b1; iaddr = $urandom_range(0, 1023); i_age = 0;
      end else if (!i_pend) begin
        ireq = 1'b0;
      end
      if (!d_pend && c < 600 && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1; d_age = 0; daddr = $urandom_range(0, 1023);
        if ($urandom_range(0, 2) == 0) begin
          dwe = 1'b1; dreq = 1'($urandom_range(0, 1)); dwdata = $urandom;
        end else begin
          dwe = 1'b0; dreq = 1'b1;
        end
      end else if (!d_pend) begin
        dreq = 1'b0; dwe = 1'b0;
      end
      @(negedge clk);
      if (!ireq) d_streak = 0;
      if (i_pend) begin
        if (!iwait) begin
          chk("rnd_fetch", iinstn, ref_mem[iaddr[9:2]]);
          chk("rnd_i_latency", (i_age <= 40) ? 32'd1 : 32'd0, 32'd1);
          i_pend = 1'b0; n_done++; d_streak = 0;
        end else begin
          i_age++;
        end
      end
      if (d_pend) begin
        if (!dwait) begin
          if (dwe) ref_mem[daddr[9:2]] = dwdata;
          else chk("rnd_load", drdata, ref_mem[daddr[9:2]]);
          chk("rnd_d_latency", (d_age <= 20) ? 32'd1 : 32'd0, 32'd1);
          if (ireq) begin
            d_streak++;
            chk("rnd_starve_bound", (d_streak <= STARVE_MAX + 1) ? 32'd1 : 32'd0, 32'd1);
          end
          d_pend = 1'b0; n_done++;
        end else begin
          d_age++;
        end
      end
    end
    chk("rnd_drained", {30'b0, i_pend, d_pend}, 32'h0);
    chk("rnd_txn_count", n_acks - acks0, n_done);
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
